// File: rtl/agu_pipe.sv
// agu_pipe: two-stage valid/ready address generation unit. Adds base+imm, translates
// through a small page-mapping table (MMIO window untranslated) and formats the access.
module agu_pipe #(
  parameter int         MAP_ENTRIES = 16,
  parameter int         PAGE_BITS   = 9,
  parameter int         SQN_W       = 6,
  parameter int         TAG_W       = 6,
  parameter logic [7:0] MMIO_PREFIX = 8'hFF,
  parameter bit         SPLIT_EN    = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              IN_flush,
  input  logic [SQN_W-1:0]                  IN_flushSqN,
  input  logic [MAP_ENTRIES*(32-PAGE_BITS)-1:0] IN_mapTags,
  input  logic [MAP_ENTRIES-1:0]            IN_mapValid,
  input  logic                              IN_valid,
  output logic                              OUT_inReady,
  input  logic [31:0]                       IN_base,
  input  logic [11:0]                       IN_imm,
  input  logic [31:0]                       IN_stData,
  input  logic [2:0]                        IN_op,
  input  logic [SQN_W-1:0]                  IN_sqN,
  input  logic [TAG_W-1:0]                  IN_tagDst,
  output logic                              OUT_valid,
  input  logic                              IN_outReady,
  output logic [31:0]                       OUT_addr,
  output logic                              OUT_isLoad,
  output logic [1:0]                        OUT_size,
  output logic                              OUT_signExt,
  output logic [1:0]                        OUT_shift,
  output logic [3:0]                        OUT_wmask,
  output logic [31:0]                       OUT_wdata,
  output logic                              OUT_part,
  output logic                              OUT_last,
  output logic [1:0]                        OUT_except,
  output logic [SQN_W-1:0]                  OUT_sqN,
  output logic [TAG_W-1:0]                  OUT_tagDst
);
  // state | meaning
  // IDLE  | S2 takes the next op (or part 0 of a crossing op) from S1
  // PART1 | part 0 of the op held in S1 sits in S2; part 1 is next
  typedef enum logic {IDLE, PART1} split_t;

  localparam int          TW        = 32 - PAGE_BITS;
  localparam int          IW        = $clog2(MAP_ENTRIES);
  localparam logic [31:0] PAGE_MASK = (32'd1 << PAGE_BITS) - 32'd1;

  function automatic logic younger(input logic [SQN_W-1:0] sqn, input logic [SQN_W-1:0] fsqn);
    logic [SQN_W-1:0] d;
    d = sqn - fsqn;
    return !d[SQN_W-1] && (d != '0);
  endfunction

  split_t state, state_n;

  logic             s1_valid, s2_valid;
  logic [31:0]      s1_vaddr, s1_data;
  logic [2:0]       s1_op;
  logic [SQN_W-1:0] s1_sqn;
  logic [TAG_W-1:0] s1_tag;

  logic in_kill, s1_kill, s2_kill, s2_free, s2_load, s1_adv, hold_split;

  logic [1:0]    off, size, fmt_exc;
  logic          is_load, sign_ext, crossing, split_op, mmio, hit, fault, fmt_last;
  logic [IW-1:0] hit_idx;
  logic [31:0]   part_addr, xlat_addr, fmt_data;
  logic [7:0]    mask_wide;
  logic [63:0]   data_wide;
  logic [3:0]    fmt_mask;

  always_comb begin
    off      = s1_vaddr[1:0];
    is_load  = s1_op <= 3'd4;
    sign_ext = s1_op <= 3'd2;
    case (s1_op)
      3'd0, 3'd3, 3'd5: size = 2'd0;
      3'd1, 3'd4, 3'd6: size = 2'd1;
      default:          size = 2'd2;
    endcase
    crossing  = (size == 2'd1 && off == 2'd3) || (size == 2'd2 && off != 2'd0);
    split_op  = SPLIT_EN && crossing;
    part_addr = split_op ? ({s1_vaddr[31:2], 2'b00} + ((state == PART1) ? 32'd4 : 32'd0))
                         : s1_vaddr;
    // Scan downwards so the lowest matching index wins.
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = MAP_ENTRIES - 1; i >= 0; i--) begin
      if (IN_mapValid[i] && IN_mapTags[i*TW +: TW] == part_addr[31:PAGE_BITS]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
    mmio      = part_addr[31:24] == MMIO_PREFIX;
    fault     = (!mmio && !hit) || (part_addr == 32'd0);
    xlat_addr = (mmio || !hit) ? part_addr
                               : ((32'(hit_idx) << PAGE_BITS) | (part_addr & PAGE_MASK));
    mask_wide = {4'b0000, (size == 2'd0) ? 4'b0001 : (size == 2'd1) ? 4'b0011 : 4'b1111} << off;
    data_wide = {32'd0, s1_data} << {off, 3'b000};
    fmt_mask  = is_load ? 4'b0000 : ((state == PART1) ? mask_wide[7:4] : mask_wide[3:0]);
    fmt_data  = is_load ? 32'd0 : ((state == PART1) ? data_wide[63:32] : data_wide[31:0]);
    fmt_exc   = fault ? 2'd2 : (crossing && !SPLIT_EN) ? 2'd1 : 2'd0;
    fmt_last  = !split_op || (state == PART1) || fault;
  end

  assign in_kill    = IN_flush && younger(IN_sqN, IN_flushSqN);
  assign s1_kill    = IN_flush && s1_valid && younger(s1_sqn, IN_flushSqN);
  assign s2_kill    = IN_flush && s2_valid && younger(OUT_sqN, IN_flushSqN);
  assign s2_free    = !s2_valid || IN_outReady || s2_kill;
  assign s2_load    = s1_valid && !s1_kill && s2_free;
  assign hold_split = (state == IDLE) && split_op && !fault;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (s1_kill)      state_n = IDLE;
    else if (s2_load) state_n = hold_split ? PART1 : IDLE;
  end

  always_comb begin
    s1_adv      = s2_load && !hold_split;
    OUT_inReady = !s1_valid || s1_adv || s1_kill;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_vaddr <= '0;
      s1_data  <= '0;
      s1_op    <= '0;
      s1_sqn   <= '0;
      s1_tag   <= '0;
    end else if (OUT_inReady) begin
      s1_valid <= IN_valid && !in_kill;
      if (IN_valid) begin
        s1_vaddr <= IN_base + {20'd0, IN_imm};
        s1_data  <= IN_stData;
        s1_op    <= IN_op;
        s1_sqn   <= IN_sqN;
        s1_tag   <= IN_tagDst;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid    <= 1'b0;
      OUT_addr    <= '0;
      OUT_isLoad  <= 1'b0;
      OUT_size    <= '0;
      OUT_signExt <= 1'b0;
      OUT_shift   <= '0;
      OUT_wmask   <= '0;
      OUT_wdata   <= '0;
      OUT_part    <= 1'b0;
      OUT_last    <= 1'b0;
      OUT_except  <= '0;
      OUT_sqN     <= '0;
      OUT_tagDst  <= '0;
    end else if (s2_free) begin
      s2_valid <= s2_load;
      if (s2_load) begin
        OUT_addr    <= xlat_addr;
        OUT_isLoad  <= is_load;
        OUT_size    <= size;
        OUT_signExt <= sign_ext;
        OUT_shift   <= off;
        OUT_wmask   <= fmt_mask;
        OUT_wdata   <= fmt_data;
        OUT_part    <= state == PART1;
        OUT_last    <= fmt_last;
        OUT_except  <= fmt_exc;
        OUT_sqN     <= s1_sqn;
        OUT_tagDst  <= s1_tag;
      end
    end
  end

  assign OUT_valid = s2_valid;

endmodule

// File: tb/tb_agu_pipe.sv
// Bench for agu_pipe: one splitting and one non-splitting instance share stimulus;
// each has its own expected-beat queue, popped when a beat is handed off.
module tb_agu_pipe;
  localparam int ME = 16;
  localparam int PB = 9;
  localparam int TW = 32 - PB;

  typedef struct packed {
    logic [31:0] addr;
    logic        is_load;
    logic [1:0]  size;
    logic        sign_ext;
    logic [1:0]  shift;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        part;
    logic        last;
    logic [1:0]  exc;
    logic [5:0]  sqn;
    logic [5:0]  tag;
  } beat_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] base;
    logic [11:0] imm;
    logic [31:0] data;
    int          nb;
    logic [31:0] addr0;
    logic [3:0]  mask0;
    logic [31:0] wdata0;
    logic [1:0]  exc0;
    logic [1:0]  shift;
    logic [31:0] addr1;
    logic [3:0]  mask1;
    logic [31:0] wdata1;
    logic [1:0]  exc1;
    logic [31:0] addr_ns;
    logic [1:0]  exc_ns;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [5:0] flush_sqn = '0;
  logic [ME*TW-1:0] map_tags;
  logic [ME-1:0] map_valid;
  logic v1 = 1'b0, v0 = 1'b0;
  logic [31:0] in_base = '0, in_data = '0;
  logic [11:0] in_imm = '0;
  logic [2:0] in_op = '0;
  logic [5:0] in_sqn = '0, in_tag = '0;
  logic out_ready = 1'b1;

  logic rdy1, rdy0, ov1, ov0;
  logic [31:0] a1, a0, wd1, wd0;
  logic il1, il0, se1, se0, pt1, pt0, ls1, ls0;
  logic [1:0] sz1, sz0, sh1, sh0, ex1, ex0;
  logic [3:0] wm1, wm0;
  logic [5:0] sq1, sq0, tg1, tg0;
  beat_t g1, g0;

  assign g1 = {a1, il1, sz1, se1, sh1, wm1, wd1, pt1, ls1, ex1, sq1, tg1};
  assign g0 = {a0, il0, sz0, se0, sh0, wm0, wd0, pt0, ls0, ex0, sq0, tg0};

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit rand_rdy = 1'b0;
  beat_t q1[$];
  beat_t q0[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  agu_pipe #(.SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .IN_flush(flush), .IN_flushSqN(flush_sqn),
    .IN_mapTags(map_tags), .IN_mapValid(map_valid), .IN_valid(v1), .OUT_inReady(rdy1),
    .IN_base(in_base), .IN_imm(in_imm), .IN_stData(in_data), .IN_op(in_op),
    .IN_sqN(in_sqn), .IN_tagDst(in_tag), .OUT_valid(ov1), .IN_outReady(out_ready),
    .OUT_addr(a1), .OUT_isLoad(il1), .OUT_size(sz1), .OUT_signExt(se1), .OUT_shift(sh1),
    .OUT_wmask(wm1), .OUT_wdata(wd1), .OUT_part(pt1), .OUT_last(ls1), .OUT_except(ex1),
    .OUT_sqN(sq1), .OUT_tagDst(tg1));

  agu_pipe #(.SPLIT_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .IN_flush(flush), .IN_flushSqN(flush_sqn),
    .IN_mapTags(map_tags), .IN_mapValid(map_valid), .IN_valid(v0), .OUT_inReady(rdy0),
    .IN_base(in_base), .IN_imm(in_imm), .IN_stData(in_data), .IN_op(in_op),
    .IN_sqN(in_sqn), .IN_tagDst(in_tag), .OUT_valid(ov0), .IN_outReady(out_ready),
    .OUT_addr(a0), .OUT_isLoad(il0), .OUT_size(sz0), .OUT_signExt(se0), .OUT_shift(sh0),
    .OUT_wmask(wm0), .OUT_wdata(wd0), .OUT_part(pt0), .OUT_last(ls0), .OUT_except(ex0),
    .OUT_sqN(sq0), .OUT_tagDst(tg0));

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Load wdata carries no meaning, so it is left out of the comparison.
  task automatic check_beat(input string name, input beat_t got, input beat_t exp);
    beat_t a, b;
    a = got;
    b = exp;
    if (b.is_load) begin
      a.wdata = '0;
      b.wdata = '0;
    end
    checks++;
    if (a !== b) begin
      errors++;
      $display("FAIL %s: got %h expected %h (addr %h/%h mask %h/%h exc %0d/%0d sqn %0d/%0d)",
               name, got, exp, got.addr, exp.addr, got.wmask, exp.wmask, got.exc, exp.exc,
               got.sqn, exp.sqn);
    end
  endtask

  function automatic vec_t mkv(input logic [2:0] op, input logic [31:0] base,
                               input logic [11:0] imm, input logic [31:0] data, input int nb,
                               input logic [31:0] ad0, input logic [3:0] m0,
                               input logic [31:0] d0, input logic [1:0] e0,
                               input logic [1:0] sh, input logic [31:0] ad1,
                               input logic [3:0] m1, input logic [31:0] d1,
                               input logic [1:0] e1, input logic [31:0] ans,
                               input logic [1:0] ens);
    vec_t v;
    v.op = op; v.base = base; v.imm = imm; v.data = data; v.nb = nb;
    v.addr0 = ad0; v.mask0 = m0; v.wdata0 = d0; v.exc0 = e0; v.shift = sh;
    v.addr1 = ad1; v.mask1 = m1; v.wdata1 = d1; v.exc1 = e1;
    v.addr_ns = ans; v.exc_ns = ens;
    return v;
  endfunction

  // which: 0 = first/only beat (split build), 1 = second beat, 2 = non-split build
  function automatic beat_t mk(input vec_t v, input int which, input logic [5:0] s,
                               input logic [5:0] t);
    beat_t b;
    b.is_load  = v.op <= 3'd4;
    b.size     = (v.op == 3'd0 || v.op == 3'd3 || v.op == 3'd5) ? 2'd0 :
                 (v.op == 3'd1 || v.op == 3'd4 || v.op == 3'd6) ? 2'd1 : 2'd2;
    b.sign_ext = v.op <= 3'd2;
    b.shift    = v.shift;
    b.sqn      = s;
    b.tag      = t;
    b.part     = (which == 1);
    b.last     = (which != 0) || (v.nb == 1);
    if (which == 1) begin
      b.addr = v.addr1; b.wmask = v.mask1; b.wdata = v.wdata1; b.exc = v.exc1;
    end else begin
      b.addr  = (which == 2) ? v.addr_ns : v.addr0;
      b.exc   = (which == 2) ? v.exc_ns : v.exc0;
      b.wmask = v.mask0;
      b.wdata = v.wdata0;
    end
    return b;
  endfunction

  task automatic send(input vec_t v, input logic [5:0] s, input logic [5:0] t, input int n1);
    bit d1, d0;
    int n;
    in_base = v.base; in_imm = v.imm; in_data = v.data; in_op = v.op;
    in_sqn = s; in_tag = t;
    v1 = 1'b1; v0 = 1'b1; d1 = 1'b0; d0 = 1'b0; n = 0;
    while (!(d1 && d0)) begin
      @(negedge clk);
      if (v1 && rdy1) begin
        d1 = 1'b1;
        if (n1 >= 1) q1.push_back(mk(v, 0, s, t));
        if (n1 >= 2) q1.push_back(mk(v, 1, s, t));
      end
      if (v0 && rdy0) begin
        d0 = 1'b1;
        q0.push_back(mk(v, 2, s, t));
      end
      @(posedge clk);
      #1;
      if (d1) v1 = 1'b0;
      if (d0) v0 = 1'b0;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: sqn %0d not accepted after %0d cycles", s, n);
        v1 = 1'b0; v0 = 1'b0;
        break;
      end
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q1.size() != 0 || q0.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    check_val(name, 32'(q1.size() + q0.size()), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  beat_t hold1, hold0;
  bit stall1 = 1'b0, stall0 = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (stall1) check_beat("hold_split_inst", g1, hold1);
      if (ov1 && out_ready) begin
        if (q1.size() == 0) check_beat("unexpected_beat_split_inst", g1, '0);
        else check_beat("beat_split_inst", g1, q1.pop_front());
      end
      stall1 = ov1 && !out_ready && !flush;
      hold1  = g1;
      if (stall0) check_beat("hold_nosplit_inst", g0, hold0);
      if (ov0 && out_ready) begin
        if (q0.size() == 0) check_beat("unexpected_beat_nosplit_inst", g0, '0);
        else check_beat("beat_nosplit_inst", g0, q0.pop_front());
      end
      stall0 = ov0 && !out_ready && !flush;
      hold0  = g0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t va, vb;
    int n;
    map_tags = '1;
    map_tags[0*TW +: TW] = 23'h0;
    map_tags[3*TW +: TW] = 23'h10;
    map_tags[5*TW +: TW] = 23'h10;
    map_tags[7*TW +: TW] = 23'h20;
    map_tags[9*TW +: TW] = 23'h80;
    map_valid = 16'b0000_0000_1010_1001;

    //            op    base          imm     data          nb addr0         m0      wdata0        e0 sh addr1         m1      wdata1        e1 addr_ns       e_ns
    vecs.push_back(mkv(3'd7, 32'h0000_2000, 12'h004, 32'h1122_3344, 1, 32'h0000_0604, 4'b1111, 32'h1122_3344, 0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0000_0604, 0));
    vecs.push_back(mkv(3'd7, 32'hFF00_0001, 12'h000, 32'hAABB_CCDD, 2, 32'hFF00_0000, 4'b1110, 32'hBBCC_DD00, 0, 1, 32'hFF00_0004, 4'b0001, 32'h0000_00AA, 0, 32'hFF00_0001, 1));
    vecs.push_back(mkv(3'd1, 32'hFF00_0003, 12'h000, 32'h0, 2, 32'hFF00_0000, 4'b0000, 32'h0, 0, 3, 32'hFF00_0004, 4'b0000, 32'h0, 0, 32'hFF00_0003, 1));
    vecs.push_back(mkv(3'd1, 32'hFF00_0001, 12'h000, 32'h0, 1, 32'hFF00_0001, 4'b0000, 32'h0, 0, 1, 32'h0, 4'h0, 32'h0, 0, 32'hFF00_0001, 0));
    vecs.push_back(mkv(3'd2, 32'h0001_0000, 12'h000, 32'h0, 1, 32'h0001_0000, 4'b0000, 32'h0, 2, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0001_0000, 2));
    vecs.push_back(mkv(3'd2, 32'h0000_0000, 12'h000, 32'h0, 1, 32'h0000_0000, 4'b0000, 32'h0, 2, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0000_0000, 2));
    vecs.push_back(mkv(3'd5, 32'h0000_4000, 12'h002, 32'h0000_00CD, 1, 32'h0000_0E02, 4'b0100, 32'h00CD_0000, 0, 2, 32'h0, 4'h0, 32'h0, 0, 32'h0000_0E02, 0));
    vecs.push_back(mkv(3'd6, 32'h0000_2000, 12'h002, 32'h0000_BEEF, 1, 32'h0000_0602, 4'b1100, 32'hBEEF_0000, 0, 2, 32'h0, 4'h0, 32'h0, 0, 32'h0000_0602, 0));
    vecs.push_back(mkv(3'd3, 32'hFF00_0007, 12'h000, 32'h0, 1, 32'hFF00_0007, 4'b0000, 32'h0, 0, 3, 32'h0, 4'h0, 32'h0, 0, 32'hFF00_0007, 0));
    vecs.push_back(mkv(3'd7, 32'h0000_2001, 12'h1FE, 32'h1234_5678, 2, 32'h0000_07FC, 4'b1000, 32'h7800_0000, 0, 3, 32'h0000_2200, 4'b0111, 32'h0012_3456, 2, 32'h0000_07FF, 1));
    vecs.push_back(mkv(3'd2, 32'h0001_0002, 12'h000, 32'h0, 1, 32'h0001_0000, 4'b0000, 32'h0, 2, 2, 32'h0, 4'h0, 32'h0, 0, 32'h0001_0002, 2));
    vecs.push_back(mkv(3'd4, 32'hFF00_0002, 12'h000, 32'h0, 1, 32'hFF00_0002, 4'b0000, 32'h0, 0, 2, 32'h0, 4'h0, 32'h0, 0, 32'hFF00_0002, 0));
    vecs.push_back(mkv(3'd0, 32'hFFFF_FFFF, 12'h001, 32'h0, 1, 32'h0000_0000, 4'b0000, 32'h0, 2, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0000_0000, 2));

    // Reset, then async reset with ops in flight, then first-op latency.
    in_base = vecs[0].base; in_imm = vecs[0].imm; in_data = vecs[0].data;
    in_op = vecs[0].op; in_sqn = 6'd1; in_tag = 6'd1;
    v1 = 1'b1; v0 = 1'b1;
    #1 rst = 1'b0;
    #11;
    check_val("reset_valid", {30'd0, ov1, ov0}, 32'd0);
    check_val("reset_addr", a1 | a0, 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_val("inflight_valid", {31'd0, ov1}, 32'd1);
    rst = 1'b0;
    #1;
    check_val("async_reset_valid", {30'd0, ov1, ov0}, 32'd0);
    check_val("async_reset_outputs", a1 | {28'd0, wm1} | {26'd0, sq1}, 32'd0);
    @(negedge clk) rst = 1'b1;
    #1;
    check_val("ready_after_reset", {30'd0, rdy1, rdy0}, 32'd3);
    @(posedge clk);
    #1 v1 = 1'b0; v0 = 1'b0;
    @(negedge clk);
    check_val("latency_n1_valid", {31'd0, ov1}, 32'd0);
    @(negedge clk);
    check_val("latency_n2_valid", {31'd0, ov1}, 32'd1);
    check_val("latency_n2_addr", a1, 32'h0000_0604);
    @(posedge clk);
    #1 mon_en = 1'b1;

    // Table vectors under random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < vecs.size(); i++)
      send(vecs[i], 6'(10 + i), 6'(i), vecs[i].nb);
    rand_rdy = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain("table_drain");

    // Flush while part 1 of a split op (sqN 5) waits in S2 and sqN 3 sits in S1.
    va = vecs[1];
    vb = vecs[3];
    fork
      begin
        send(va, 6'd5, 6'd40, 1);
        send(vb, 6'd3, 6'd41, 1);
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!(ov1 && pt1 == 1'b0 && sq1 == 6'd5) && n < 100);
        if (n >= 100) begin
          checks++; errors++;
          $display("FAIL flush_part0_timeout: part 0 of sqN 5 not seen");
        end
        @(posedge clk);
        #1 out_ready = 1'b0; flush = 1'b1; flush_sqn = 6'd3;
        @(posedge clk);
        #1 flush = 1'b0; out_ready = 1'b1;
      end
    join
    drain("flush_drain");
    repeat (5) @(posedge clk);
    check_val("no_stray_beat", {30'd0, ov1, ov0}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/agu_pipe.md
Name: agu_pipe

Overview:
- Parametrised, two-stage, valid/ready-pipelined address generation unit for the load/store path.
- Computes base+imm, translates the address through a configurable page-mapping table (MMIO window passes through untranslated), and formats byte masks, shifted store data and load extraction info.
- New over the previous single-stage AGU: backpressure, configurable table and page size, branch flush of in-flight ops in both stages, and optional splitting of word-crossing accesses into two aligned parts instead of raising a misalignment exception.

Parameters:
- MAP_ENTRIES, 16, number of page-mapping entries (power of two, 2..64)
- PAGE_BITS, 9, page offset width; tag width TW = 32-PAGE_BITS
- SQN_W, 6, sequence-number width
- TAG_W, 6, destination-register tag width
- MMIO_PREFIX, 8'hFF, addr[31:24] value that bypasses translation
- SPLIT_EN, 1, 1 = split word-crossing accesses; 0 = raise misaligned exception

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- IN_flush  in  1  branch mispredict flush
- IN_flushSqN  in  SQN_W  sqN of the mispredicted branch
- IN_mapTags  in  MAP_ENTRIES*TW  packed page tags; entry i at [i*TW +: TW]
- IN_mapValid  in  MAP_ENTRIES  per-entry valid
- IN_valid  in  1  input op valid
- OUT_inReady  out  1  AGU accepts input this cycle
- IN_base  in  32  base register value
- IN_imm  in  12  immediate, zero-extended
- IN_stData  in  32  store data
- IN_op  in  3  0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW
- IN_sqN  in  SQN_W  op sequence number
- IN_tagDst  in  TAG_W  load destination tag
- OUT_valid  out  1  output op valid
- IN_outReady  in  1  consumer accepts output
- OUT_addr  out  32  physical address, word aligned when split
- OUT_isLoad  out  1  load (1) / store (0)
- OUT_size  out  2  0 byte, 1 half, 2 word
- OUT_signExt  out  1  load sign extension
- OUT_shift  out  2  byte offset in word for load extraction
- OUT_wmask  out  4  store byte enables
- OUT_wdata  out  32  shifted store data
- OUT_part  out  1  0 first/only part, 1 second part
- OUT_last  out  1  final part of this op
- OUT_except  out  2  0 none, 1 misaligned, 2 access fault
- OUT_sqN  out  SQN_W  passthrough
- OUT_tagDst  out  TAG_W  passthrough

Behaviour:
- Reset (rst=0, async): S1/S2 valid = 0, split state idle. All outputs 0; OUT_inReady = 1 after reset deasserts.
- Stage 1 (S1) registers vaddr = IN_base + IN_imm (mod 2^32) plus op, data, sqN and tag on IN_valid && OUT_inReady.
- OUT_inReady = !S1.valid || (S1 advances this cycle).
- Stage 2 (S2) registers formatted output from S1. S2 advances when !OUT_valid || IN_outReady; OUT_valid mirrors S2.valid.
- Latency: accepted in cycle N -> OUT_valid in cycle N+2 with no backpressure. Throughput: 1 op/cycle, except split ops take 2 output beats.
- Word crossing:
  - half at offset 3, or word at offset != 0.
  - half at offset 1 is legal unsplit, with shift = 1.
  - byte access never crosses.
- SPLIT_EN=1, crossing op:
  - S2 emits part 0 at vaddr&~3, then part 1 at (vaddr&~3)+4. S1 is held during part 0.
  - Store part 0: wmask = bytes off..3, wdata = data << 8*off.
  - Store part 1: remaining low bytes, wdata = data >> 8*(4-off).
  - Load: shift = off on both parts; part 1 OUT_last = 1.
- SPLIT_EN=0, crossing op: single beat, except = 1, addr = vaddr unmodified.
- Translation, applied per part address A:
  - A[31:24]==MMIO_PREFIX -> passthrough.
  - else if the lowest index i with IN_mapValid[i] && tag == A[31:PAGE_BITS] exists -> {zeros, i, A[PAGE_BITS-1:0]}.
  - else except = 2, addr = A.
  - A==0 -> except = 2.
  - An access fault on part 0 suppresses part 1.
  - Access fault has priority over misaligned.
- Unsplit store masks and data:
  - SB: mask 1<<off, data << 8*off.
  - SH: mask 0011 or 0110 or 1100 by offset, data << 8*off.
  - SW: mask 1111.
  - Loads: wmask = 0.
- Flush: when IN_flush, any op in S1, S2 or the input with $signed(sqN - IN_flushSqN) > 0 is killed that cycle, including mid-split (part 1 is not emitted). An equal sqN is kept. A killed S2 beat drops OUT_valid next cycle regardless of IN_outReady.
- Backpressure: S2 holds all outputs stable while OUT_valid && !IN_outReady.

Test Plan:
- Reset with IN_valid=1 in flight -> OUT_valid=0 immediately; first accepted op appears 2 cycles after accept.
- Mapping tag entry 3 = 0x000010, op SW, base=0x2000, imm=0x004 -> OUT_addr=0x0000_0604, wmask=1111, except=0.
- SPLIT_EN=1, SW base=0xFF00_0001 data=0xAABBCCDD -> beat0 addr=0xFF00_0000 wmask=1110 wdata=0xBBCCDD00; beat1 addr=0xFF00_0004 wmask=0001 wdata=0x000000AA last=1.
- SPLIT_EN=0, LH addr 0xFF00_0003 -> single beat except=1; LH addr 0xFF00_0001 -> except=0, shift=1.
- Unmapped LW at 0x0001_0000 -> except=2; LW at address 0 -> except=2.
- Split in progress with sqN=5, IN_flush sqN=3 -> part 1 never emitted; concurrent S1 op with sqN=3 survives.
